// File: rtl/egg_timer_ctrl_if.sv
// Button pulses into, and countdown status out of, the egg timer controller.
// The master side drives the buttons; the slave side is the controller.
interface egg_timer_ctrl_if;
    logic        btn_start;
    logic        btn_min;
    logic        btn_sec;
    logic        btn_clear;
    logic [11:0] count;
    logic        running;
    logic        alarm;
    logic [1:0]  state;

    modport master (
        output btn_start, btn_min, btn_sec, btn_clear,
        input  count, running, alarm, state
    );

    modport slave (
        input  btn_start, btn_min, btn_sec, btn_clear,
        output count, running, alarm, state
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown: loads a seconds counter from min/sec buttons, counts it
// down once per prescaled second, supports pause/resume and a timed alarm at zero.
module egg_timer_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int MAX_COUNT   = 3599,
    parameter int ALARM_TICKS = 10
) (
    input  logic           clk,
    input  logic           rst,
    egg_timer_ctrl_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
    localparam logic [11:0]   MAX12      = 12'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        RUN   = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   count_q, count_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [AW-1:0] alarm_tmr_q, alarm_tmr_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;

    logic          tick;
    logic [12:0]   plus_min;
    logic [12:0]   plus_sec;
    logic [11:0]   sat_min;
    logic [11:0]   sat_sec;
    logic          loadable;

    assign tick     = (prescaler_q == PRE_LAST);
    assign plus_min = {1'b0, count_q} + 13'd60;
    assign plus_sec = {1'b0, count_q} + 13'd1;
    assign sat_min  = (plus_min > {1'b0, MAX12}) ? MAX12 : plus_min[11:0];
    assign sat_sec  = (plus_sec > {1'b0, MAX12}) ? MAX12 : plus_sec[11:0];
    assign loadable = (state_q == IDLE) || (state_q == SET);

    // Only the highest-priority pulse of a cycle is acted upon.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prescaler_d = prescaler_q;
        alarm_tmr_d = alarm_tmr_q;
        if (bus.btn_clear) begin
            state_d     = IDLE;
            count_d     = '0;
            prescaler_d = '0;
            alarm_tmr_d = '0;
        end else if (bus.btn_start) begin
            case (state_q)
                SET: begin
                    state_d     = RUN;
                    prescaler_d = '0;
                end
                RUN: begin
                    state_d     = SET;
                    prescaler_d = '0;
                end
                ALARM: begin
                    state_d     = IDLE;
                    count_d     = '0;
                    prescaler_d = '0;
                    alarm_tmr_d = '0;
                end
                default: ;
            endcase
        end else if (bus.btn_min && loadable) begin
            state_d = SET;
            count_d = sat_min;
        end else if (bus.btn_sec && loadable) begin
            state_d = SET;
            count_d = sat_sec;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        prescaler_d = '0;
                        count_d     = count_q - 12'd1;
                        if (count_q == 12'd1) begin
                            state_d     = ALARM;
                            alarm_tmr_d = '0;
                        end
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                    end
                end
                ALARM: begin
                    if (tick) begin
                        prescaler_d = '0;
                        if (alarm_tmr_q == ALARM_LAST) begin
                            state_d     = IDLE;
                            alarm_tmr_d = '0;
                        end else begin
                            alarm_tmr_d = alarm_tmr_q + 1'b1;
                        end
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            prescaler_q <= '0;
            alarm_tmr_q <= '0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prescaler_q <= prescaler_d;
            alarm_tmr_q <= alarm_tmr_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Egg timer controller bench: directed scenarios then random button traffic,
// every cycle compared against a time-based reference model.
module tb_egg_timer_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int MAX_COUNT   = 3599;
    localparam int ALARM_TICKS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    egg_timer_ctrl_if bus ();

    egg_timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .MAX_COUNT  (MAX_COUNT),
        .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: RUN count derived from elapsed cycles since (re)start.
    int m_mode;       // 0 idle, 1 set, 2 run, 3 alarm
    int m_count;
    int m_base;
    int m_run_cyc;
    int m_alarm_cyc;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit mn, input bit sc, input bit cl);
        if (r) begin
            m_mode = 0; m_count = 0; m_run_cyc = 0; m_alarm_cyc = 0;
        end else if (cl) begin
            m_mode = 0; m_count = 0;
        end else if (st) begin
            if (m_mode == 1) begin
                m_mode = 2; m_base = m_count; m_run_cyc = 0;
            end else if (m_mode == 2) begin
                m_mode = 1;
            end else if (m_mode == 3) begin
                m_mode = 0; m_count = 0;
            end
        end else if (mn && m_mode <= 1) begin
            m_count = (m_count + 60 > MAX_COUNT) ? MAX_COUNT : m_count + 60;
            m_mode  = 1;
        end else if (sc && m_mode <= 1) begin
            m_count = (m_count + 1 > MAX_COUNT) ? MAX_COUNT : m_count + 1;
            m_mode  = 1;
        end else if (m_mode == 2) begin
            m_run_cyc++;
            m_count = m_base - m_run_cyc / TICK_DIV;
            if (m_count == 0) begin
                m_mode = 3; m_alarm_cyc = 0;
            end
        end else if (m_mode == 3) begin
            m_alarm_cyc++;
            if (m_alarm_cyc == ALARM_TICKS * TICK_DIV) m_mode = 0;
        end
    endtask

    task automatic compare_all(input string who);
        check_val({who, ".count"},   int'(bus.count),   m_count);
        check_val({who, ".state"},   int'(bus.state),   m_mode);
        check_val({who, ".running"}, int'(bus.running), int'(m_mode == 2));
        check_val({who, ".alarm"},   int'(bus.alarm),   int'(m_mode == 3));
    endtask

    // One clock: drive pulses, advance model at the edge, compare at negedge.
    task automatic step(input bit r, input bit st, input bit mn, input bit sc, input bit cl,
                        input string who);
        rst = r; bus.btn_start = st; bus.btn_min = mn; bus.btn_sec = sc; bus.btn_clear = cl;
        @(posedge clk);
        model_step(r, st, mn, sc, cl);
        @(negedge clk);
        rst = 1'b0; bus.btn_start = 1'b0; bus.btn_min = 1'b0; bus.btn_sec = 1'b0; bus.btn_clear = 1'b0;
        compare_all(who);
    endtask

    task automatic idle(input int n, input string who);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, who);
    endtask

    initial begin
        int high_cycles;
        m_mode = 0; m_count = 0; m_base = 0; m_run_cyc = 0; m_alarm_cyc = 0;
        rst = 1'b1;
        bus.btn_start = 1'b0; bus.btn_min = 1'b0; bus.btn_sec = 1'b0; bus.btn_clear = 1'b0;
        @(negedge clk);

        step(1, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, "reset");
        check_val("reset_count", int'(bus.count), 0);
        check_val("reset_state", int'(bus.state), 0);
        $display("reset: count=%0d state=%0d", bus.count, bus.state);

        step(0, 0, 1, 0, 0, "load_min");
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0, "load_sec");
        check_val("load_90", int'(bus.count), 90);
        check_val("load_set", int'(bus.state), 1);
        $display("load: count=%0d state=%0d", bus.count, bus.state);

        step(0, 0, 0, 0, 1, "clear");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "load3");
        step(0, 1, 0, 0, 0, "start");
        idle(4, "run");
        check_val("run_after4", int'(bus.count), 2);
        idle(4, "run");
        check_val("run_after8", int'(bus.count), 1);
        step(0, 1, 0, 0, 0, "pause");
        idle(20, "paused");
        check_val("pause_hold", int'(bus.count), 1);
        check_val("pause_set", int'(bus.state), 1);
        step(0, 1, 0, 0, 0, "resume");
        idle(4, "resume_run");
        check_val("final_count", int'(bus.count), 0);
        check_val("final_alarm", int'(bus.alarm), 1);
        $display("run/pause: count=%0d alarm=%0d", bus.count, bus.alarm);

        high_cycles = 1;
        for (int i = 0; i < 40 && bus.alarm === 1'b1; i++) begin
            step(0, 0, 0, 0, 0, "alarm");
            if (bus.alarm === 1'b1) high_cycles++;
        end
        check_val("alarm_len", high_cycles, ALARM_TICKS * TICK_DIV);
        check_val("alarm_to_idle", int'(bus.state), 0);
        $display("alarm: high for %0d cycles", high_cycles);

        step(0, 0, 0, 1, 0, "load1");
        step(0, 1, 0, 0, 0, "start1");
        idle(4, "run1");
        check_val("alarm2_on", int'(bus.alarm), 1);
        step(0, 1, 0, 0, 0, "ack");
        check_val("ack_state", int'(bus.state), 0);
        check_val("ack_alarm", int'(bus.alarm), 0);
        $display("ack: state=%0d alarm=%0d", bus.state, bus.alarm);

        for (int i = 0; i < 61; i++) step(0, 0, 1, 0, 0, "sat_min");
        check_val("sat_3599", int'(bus.count), MAX_COUNT);
        step(0, 0, 0, 1, 0, "sat_sec");
        check_val("sat_hold", int'(bus.count), MAX_COUNT);
        $display("saturate: count=%0d", bus.count);

        step(0, 1, 0, 0, 0, "start_sat");
        idle(2, "run_sat");
        step(0, 0, 1, 0, 1, "clear_min");
        check_val("clr_count", int'(bus.count), 0);
        check_val("clr_state", int'(bus.state), 0);
        step(0, 1, 0, 0, 0, "start_idle");
        check_val("idle_start", int'(bus.state), 0);
        $display("priority/clear: count=%0d state=%0d", bus.count, bus.state);

        for (int n = 0; n < 3000; n++) begin
            int pick;
            bit r, st, mn, sc, cl;
            r = 0; st = 0; mn = 0; sc = 0; cl = 0;
            pick = $urandom_range(0, 99);
            if (pick < 1) r = 1;
            else if (pick < 4) begin
                cl = 1; st = 1'($urandom); mn = 1'($urandom); sc = 1'($urandom);
            end else if (pick < 10) st = 1;
            else if (pick < 13) begin
                if (m_mode != 0) begin st = 1; mn = 1'($urandom); sc = ~mn; end
                else mn = 1;
            end else if (pick < 15) mn = 1;
            else if (pick < 22) sc = 1;
            else if (pick < 24) begin mn = 1; sc = 1; end
            step(r, st, mn, sc, cl, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
